// File: rtl/varint_pkg.sv
// varint_pkg: shared types and constants for the LEB128 varint decoder.
// Imported by varint_accum and varint_decoder.
package varint_pkg;

    localparam int MAX_BYTES      = 10;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BYTE = 3'b010,
        ST_EMIT = 3'b100
    } state_t;

    // True when any strobed byte sits above ptr in the word.
    function automatic logic remaining_strb(
        input logic [3:0] wstrb,
        input logic [1:0] ptr
    );
        logic [3:0] above;
        above = 4'b1110 << ptr;
        return |(wstrb & above);
    endfunction

endpackage

// File: rtl/varint_accum.sv
// varint_accum: 7-bit group shift/OR accumulator with group counter.
// overflow flags the add that brings the count to MAX_BYTES.
module varint_accum
    import varint_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        add,
    input  logic [6:0]  payload,
    output logic [63:0] acc,
    output logic [3:0]  group,
    output logic        overflow
);

    logic [63:0] addend;

    // Position the payload at its group; the 10th group keeps only bit 0.
    always_comb begin
        addend   = {57'b0, payload} << (7 * group);
        overflow = add && (group == 4'(MAX_BYTES - 1));
    end

    // Accumulate one group per add; clear wins over add.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            group <= '0;
        end else if (clear) begin
            acc   <= '0;
            group <= '0;
        end else if (add) begin
            acc   <= acc | addend;
            group <= group + 4'd1;
        end
    end

endmodule

// File: rtl/varint_decoder.sv
// varint_decoder: pops 32-bit FIFO words and decodes LEB128 varints.
// Optional macro VARINT_ZIGZAG_EN adds zigzag_mode for sint fields.
module varint_decoder
    import varint_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              varint_in_fifo_empty,
    input  logic [DATA_W-1:0] varint_in_fifo_data,
    input  logic [3:0]        varint_in_fifo_wstrb,
    input  logic              varint_in_fifo_last,
    output logic              varint_in_fifo_pop,
`ifdef VARINT_ZIGZAG_EN
    input  logic              zigzag_mode,
`endif
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [63:0]       dec_value,
    output logic              dec_last,
    output logic              dec_error,
    output logic              busy
);

    localparam logic [1:0] LAST_PTR = 2'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [3:0]        strb_q, strb_d;
    logic              last_q, last_d;
    logic              disc_q, disc_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
`ifdef VARINT_ZIGZAG_EN
    logic              zz_q, zz_d;
`endif

    logic [7:0]  cur_byte;
    logic        acc_clear;
    logic        acc_add;
    logic [63:0] acc;
    logic [3:0]  group;
    logic        overflow;
    logic        complete;

    varint_accum u_accum (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .add      (acc_add),
        .payload  (cur_byte[6:0]),
        .acc      (acc),
        .group    (group),
        .overflow (overflow)
    );

    // State, word latch and per-varint flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            disc_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef VARINT_ZIGZAG_EN
            zz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            disc_q  <= disc_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef VARINT_ZIGZAG_EN
            zz_q    <= zz_d;
`endif
        end
    end

    // Next-state, byte consumption, pop and accumulator control.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        word_d    = word_q;
        strb_d    = strb_q;
        last_d    = last_q;
        disc_d    = disc_q;
        err_d     = err_q;
        done_d    = done_q;
`ifdef VARINT_ZIGZAG_EN
        zz_d      = zz_q;
`endif
        cur_byte  = word_q[8*ptr_q +: 8];
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        complete  = 1'b0;
        varint_in_fifo_pop = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!varint_in_fifo_empty) begin
                    word_d  = varint_in_fifo_data;
                    strb_d  = varint_in_fifo_wstrb;
                    last_d  = varint_in_fifo_last;
                    ptr_d   = '0;
                    state_d = ST_BYTE;
                end
            end
            ST_BYTE: begin
                if (strb_q[ptr_q] && disc_q) begin
                    // Swallow the tail of an overlong varint.
                    if (!cur_byte[7]) disc_d = 1'b0;
                end else if (strb_q[ptr_q]) begin
                    acc_add = 1'b1;
`ifdef VARINT_ZIGZAG_EN
                    if (group == 4'd0) zz_d = zigzag_mode;
`endif
                    if (!cur_byte[7]) begin
                        complete = 1'b1;
                    end else if (overflow) begin
                        complete = 1'b1;
                        err_d    = 1'b1;
                        disc_d   = 1'b1;
                    end
                end
                if (complete) begin
                    state_d = ST_EMIT;
                end else if (ptr_q == LAST_PTR) begin
                    varint_in_fifo_pop = 1'b1;
                    if (last_q && (group != 4'd0 || acc_add)) begin
                        // Message ended inside a varint: truncated.
                        state_d = ST_EMIT;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        if (last_q) disc_d = 1'b0;
                    end
                end else begin
                    ptr_d = ptr_q + 2'd1;
                end
            end
            ST_EMIT: begin
                if (dec_ready) begin
                    acc_clear = 1'b1;
                    err_d     = 1'b0;
                    if (done_q) begin
                        done_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (ptr_q == LAST_PTR) begin
                        varint_in_fifo_pop = 1'b1;
                        state_d = ST_IDLE;
                        if (last_q) disc_d = 1'b0;
                    end else begin
                        ptr_d   = ptr_q + 2'd1;
                        state_d = ST_BYTE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stream; value and flags are zero outside EMIT.
    always_comb begin
        dec_valid = (state_q == ST_EMIT);
        busy      = (state_q != ST_IDLE);
        dec_value = '0;
        dec_last  = dec_valid && last_q && !remaining_strb(strb_q, ptr_q);
        dec_error = dec_valid && err_q;
        if (dec_valid) begin
`ifdef VARINT_ZIGZAG_EN
            if (zz_q) dec_value = (acc >> 1) ^ -(acc & 64'd1);
            else      dec_value = acc;
`else
            dec_value = acc;
`endif
        end
    end

endmodule

// File: tb/tb_varint_decoder.sv
// tb_varint_decoder: directed and random checks of varint_decoder
// against a byte-stream LEB128 reference model.
module tb_varint_decoder;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } word_t;

    typedef struct {
        logic [63:0] value;
        logic        last;
        logic        err;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic [3:0]  fifo_wstrb = '0;
    logic        fifo_last = 1'b0;
    logic        fifo_pop;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [63:0] dec_value;
    logic        dec_last;
    logic        dec_error;
    logic        busy;
`ifdef VARINT_ZIGZAG_EN
    logic        zigzag_mode = 1'b0;
`endif

    word_t fifo_q[$];
    out_t  exp_q[$];
    out_t  got_q[$];

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int pop_empty = 0;
    int sent = 0;
    logic pop_seen;
    logic rdy_rand = 1'b0;
    logic rdy_val = 1'b1;

    logic [63:0] m_acc = '0;
    int          m_g = 0;
    bit          m_disc = 0;

    varint_decoder dut (
        .clk                  (clk),
        .reset                (reset),
        .varint_in_fifo_empty (fifo_empty),
        .varint_in_fifo_data  (fifo_data),
        .varint_in_fifo_wstrb (fifo_wstrb),
        .varint_in_fifo_last  (fifo_last),
        .varint_in_fifo_pop   (fifo_pop),
`ifdef VARINT_ZIGZAG_EN
        .zigzag_mode          (zigzag_mode),
`endif
        .dec_valid            (dec_valid),
        .dec_ready            (dec_ready),
        .dec_value            (dec_value),
        .dec_last             (dec_last),
        .dec_error            (dec_error),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    function automatic void refresh();
        if (fifo_q.size() == 0) begin
            fifo_empty = 1'b1;
            fifo_data  = '0;
            fifo_wstrb = '0;
            fifo_last  = 1'b0;
        end else begin
            fifo_empty = 1'b0;
            fifo_data  = fifo_q[0].data;
            fifo_wstrb = fifo_q[0].strb;
            fifo_last  = fifo_q[0].last;
        end
    endfunction

    // Show-ahead FIFO: a pop seen at an edge removes the head.
    always @(posedge clk) begin
        pop_seen = fifo_pop;
        #1;
        if (pop_seen) begin
            pops++;
            if (fifo_q.size() == 0) pop_empty++;
            else void'(fifo_q.pop_front());
            refresh();
        end
    end

    // Record every accepted output.
    always @(posedge clk) begin
        if (!reset && dec_valid && dec_ready)
            got_q.push_back('{dec_value, dec_last, dec_error});
    end

    always @(negedge clk) begin
        dec_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Reference: walk the strobed bytes of a word in order.
    task automatic model_word(input logic [31:0] d, input logic [3:0] s,
                              input logic l);
        logic [7:0] b;
        logic       more;
        for (int p = 0; p < 4; p++) begin
            b = d[8*p +: 8];
            more = ((s >> (p + 1)) != 4'd0);
            if (!s[p]) continue;
            if (m_disc) begin
                if (!b[7]) m_disc = 0;
                continue;
            end
            m_acc = m_acc | (64'(b[6:0]) << (7 * m_g));
            m_g++;
            if (!b[7] || m_g == 10) begin
                exp_q.push_back('{m_acc, l && !more, b[7]});
                if (b[7]) m_disc = 1;
                m_acc = '0;
                m_g = 0;
            end
        end
        if (l) begin
            if (m_g > 0) exp_q.push_back('{m_acc, 1'b1, 1'b1});
            m_acc = '0;
            m_g = 0;
            m_disc = 0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s,
                        input logic l);
        fifo_q.push_back('{d, s, l});
        model_word(d, s, l);
        sent++;
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        int idle;
        n = 0;
        idle = 0;
        while (idle < 3 && n < budget) begin
            tick();
            n++;
            if (fifo_q.size() == 0 && !busy && !dec_valid) idle++;
            else idle = 0;
        end
        chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_value"}, got_q[i].value, exp_q[i].value);
            chk({tag, "_last"}, 64'(got_q[i].last), 64'(exp_q[i].last));
            chk({tag, "_error"}, 64'(got_q[i].err), 64'(exp_q[i].err));
        end
        chk({tag, "_pops"}, 64'(pops), 64'(sent));
        chk({tag, "_pop_empty"}, 64'(pop_empty), 64'd0);
        got_q.delete();
        exp_q.delete();
        pops = 0;
        pop_empty = 0;
        sent = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        logic [63:0] held;
        int          nw;
        int          n;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pop", 64'(fifo_pop), 64'd0);
        chk("rst_value", dec_value, 64'd0);
        chk("rst_flags", 64'({dec_last, dec_error}), 64'd0);
        reset = 1'b0;
        tick();

        send(32'h0000_0001, 4'b0001, 1'b1);
        tick();
        chk("lat_edge1", 64'(dec_valid), 64'd0);
        tick();
        chk("lat_edge2", 64'(dec_valid), 64'd1);
        drain("one", 100);
        chk("one_v", got_q.size() > 0 ? got_q[0].value : 64'hX, 64'd1);
        chk("one_l", got_q.size() > 0 ? 64'(got_q[0].last) : 64'hX, 64'd1);
        compare("one");

        send(32'h7F01_AC02, 4'hF, 1'b1);
        drain("three", 100);
        chk("three_n", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("three_v0", got_q[0].value, 64'd2);
            chk("three_v1", got_q[1].value, 64'hAC);
            chk("three_v2", got_q[2].value, 64'd127);
            chk("three_l1", 64'(got_q[1].last), 64'd0);
            chk("three_l2", 64'(got_q[2].last), 64'd1);
        end
        compare("three");

        send(32'hFFFF_FFFF, 4'hF, 1'b0);
        send(32'hFFFF_FFFF, 4'hF, 1'b0);
        send(32'h0000_01FF, 4'b0011, 1'b1);
        drain("ten", 200);
        chk("ten_v", got_q.size() > 0 ? got_q[0].value : 64'hX, '1);
        chk("ten_e", got_q.size() > 0 ? 64'(got_q[0].err) : 64'hX, 64'd0);
        chk("ten_pops", 64'(pops), 64'd3);
        compare("ten");

        send(32'hFFFF_FFFF, 4'hF, 1'b0);
        send(32'hFFFF_FFFF, 4'hF, 1'b0);
        send(32'h0001_FFFF, 4'b0111, 1'b1);
        drain("ovl", 200);
        chk("ovl_n", 64'(got_q.size()), 64'd1);
        chk("ovl_e", got_q.size() > 0 ? 64'(got_q[0].err) : 64'hX, 64'd1);
        compare("ovl");

        send(32'h0000_0080, 4'b0001, 1'b1);
        drain("trunc", 100);
        chk("trunc_e", got_q.size() > 0 ? 64'(got_q[0].err) : 64'hX, 64'd1);
        chk("trunc_l", got_q.size() > 0 ? 64'(got_q[0].last) : 64'hX, 64'd1);
        compare("trunc");

        send(32'h0000_0000, 4'b0000, 1'b1);
        drain("empty", 100);
        compare("empty");

        rdy_val = 1'b0;
        tick();
        send(32'h0000_0005, 4'b0001, 1'b1);
        n = 0;
        while (!dec_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_wait", 64'(dec_valid), 64'd1);
        held = dec_value;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(dec_valid), 64'd1);
            chk("bp_value", dec_value, held);
            chk("bp_pop", 64'(fifo_pop), 64'd0);
            chk("bp_fifo", 64'(fifo_q.size()), 64'd1);
        end
        rdy_val = 1'b1;
        drain("bp", 100);
        compare("bp");

        send(32'h0000_8080, 4'b0011, 1'b0);
        tick();
        tick();
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(dec_valid), 64'd0);
        chk("mid_rst_pop", 64'(fifo_pop), 64'd0);
        chk("mid_rst_value", dec_value, 64'd0);
        fifo_q.delete();
        refresh();
        exp_q.delete();
        got_q.delete();
        m_acc = '0;
        m_g = 0;
        m_disc = 0;
        tick();
        reset = 1'b0;
        pops = 0;
        pop_empty = 0;
        sent = 0;
        tick();
        send(32'h0000_002A, 4'b0001, 1'b1);
        drain("post_rst", 100);
        chk("post_rst_v", got_q.size() > 0 ? got_q[0].value : 64'hX, 64'd42);
        compare("post_rst");

        rdy_rand = 1'b1;
        for (int m = 0; m < 30; m++) begin
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                for (int k = 0; k < 4; k++)
                    d[8*k +: 8] = {1'($urandom_range(0, 9) < 4), 7'($urandom)};
                if (m % 7 == 3) d = 32'hFFFF_FFFF;
                s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                send(d, s, 1'(w == nw - 1));
            end
        end
        drain("rand", 20000);
        compare("rand");
        rdy_rand = 1'b0;

`ifdef VARINT_ZIGZAG_EN
        tick();
        zigzag_mode = 1'b1;
        send(32'h0000_0403, 4'b0011, 1'b1);
        drain("zz", 100);
        chk("zz_n", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("zz_m2", got_q[0].value, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("zz_p2", got_q[1].value, 64'd2);
        end
        got_q.delete();
        exp_q.delete();
        zigzag_mode = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
